// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   owner_e : who owns the memory bus this cycle (idle, core, debug/loader)
//   CNT_W   : width of the burst counter (holds MAX_BURST up to 15)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DBG  = 2'b10
    } owner_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the core port, the debug/loader port and the memory-side bus.
//   cpu_* / dbg_* : req, we, adr, wd from requesters; gnt, rd (and cpu_stall)
//                   back to them
//   mem_*         : adr, wd, we towards memory; rd (combinational) from memory
// Modports:
//   slave  : the arbiter's view
//   master : the view of whatever surrounds the arbiter (requesters + memory)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wd;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rd;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_adr;
    logic [DATA_W-1:0] dbg_wd;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rd;

    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_adr, cpu_wd,
        input  dbg_req, dbg_we, dbg_adr, dbg_wd,
        input  mem_rd,
        output cpu_gnt, cpu_stall, cpu_rd,
        output dbg_gnt, dbg_rd,
        output mem_adr, mem_wd, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_adr, cpu_wd,
        output dbg_req, dbg_we, dbg_adr, dbg_wd,
        output mem_rd,
        input  cpu_gnt, cpu_stall, cpu_rd,
        input  dbg_gnt, dbg_rd,
        input  mem_adr, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_arb_burst_cnt.sv
// -----------------------------------------------------------------------------
// mem_arb_burst_cnt
// Saturating count of consecutive grants to the current owner.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   clr        : owner goes idle -> count = 0 (highest priority)
//   load       : owner changes   -> count = 1
//   inc        : owner kept      -> count + 1, saturating at MAX
//   count      : current count
// -----------------------------------------------------------------------------
module mem_arb_burst_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX);

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would create races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && count != MAX_CNT) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one unified instruction/data memory between the multi-cycle core and
// a debug/loader port. One owner per cycle; the owner's adr/wd/we are muxed
// onto memory, read data is broadcast, and the core is stalled while it
// requests without a grant.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (clears grants immediately)
//   bus   : mem_arbiter_if.slave (core port, debug port, memory bus)
// Configuration:
//   MEM_ARB_FAIRNESS_EN defined   : burst-limited alternation, at most
//                                   MAX_BURST consecutive grants to one owner
//                                   while the other requests.
//   MEM_ARB_FAIRNESS_EN undefined : strict core priority, no burst counter.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    if (MAX_BURST < 2 || MAX_BURST > 15) begin : g_bad_burst
        $error("mem_arbiter: MAX_BURST must be in 2..15");
    end

    owner_e owner_q;
    owner_e owner_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) owner_q <= OWN_IDLE;
        else        owner_q <= owner_d;
    end

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] count;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        owner_d = OWN_IDLE;
        case ({bus.cpu_req, bus.dbg_req})
            2'b10:   owner_d = OWN_CPU;
            2'b01:   owner_d = OWN_DBG;
            2'b11: begin
                if (owner_q == OWN_IDLE)  owner_d = OWN_CPU;
                else if (count < MAX_CNT) owner_d = owner_q;
                else owner_d = (owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
            end
            default: owner_d = OWN_IDLE;
        endcase
        cnt_clr  = (owner_d == OWN_IDLE);
        cnt_load = !cnt_clr && (owner_d != owner_q);
        cnt_inc  = !cnt_clr && (owner_d == owner_q);
    end

    mem_arb_burst_cnt #(.MAX(MAX_BURST)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (count)
    );
`else
    // Debug only gets the bus on cycles where the core did not ask for it.
    always_comb begin
        owner_d = OWN_IDLE;
        if (bus.cpu_req)      owner_d = OWN_CPU;
        else if (bus.dbg_req) owner_d = OWN_DBG;
    end
`endif

    logic [ADDR_W-1:0] mux_adr;
    logic [DATA_W-1:0] mux_wd;
    logic              mux_we;

    // Write enable also needs the owner's req: the cycle after a requester
    // drops req it still owns the bus but must not write.
    always_comb begin
        mux_adr = '0;
        mux_wd  = '0;
        mux_we  = 1'b0;
        case (owner_q)
            OWN_CPU: begin
                mux_adr = bus.cpu_adr;
                mux_wd  = bus.cpu_wd;
                mux_we  = bus.cpu_req & bus.cpu_we;
            end
            OWN_DBG: begin
                mux_adr = bus.dbg_adr;
                mux_wd  = bus.dbg_wd;
                mux_we  = bus.dbg_req & bus.dbg_we;
            end
            default: ;
        endcase
    end

    assign bus.mem_adr   = mux_adr;
    assign bus.mem_wd    = mux_wd;
    assign bus.mem_we    = mux_we;
    assign bus.cpu_gnt   = (owner_q == OWN_CPU);
    assign bus.dbg_gnt   = (owner_q == OWN_DBG);
    assign bus.cpu_stall = bus.cpu_req & (owner_q != OWN_CPU);
    assign bus.cpu_rd    = bus.mem_rd;
    assign bus.dbg_rd    = bus.mem_rd;
endmodule
